// File: rtl/iob_clint_rtc_gen_pkg.sv
// Shared register map, bit positions and reset values for the CLINT real-time clock generator.
package iob_clint_rtc_gen_pkg;

   localparam int CTRL_ADDR    = 'h00;
   localparam int DIV_ADDR     = 'h04;
   localparam int STATUS_ADDR  = 'h08;
   localparam int TICK_LO_ADDR = 'h0C;
   localparam int TICK_HI_ADDR = 'h10;

   localparam int CTRL_EN_BIT     = 0;
   localparam int CTRL_CLR_BIT    = 1;
   localparam int STATUS_RUN_BIT  = 0;
   localparam int STATUS_PEND_BIT = 1;

   localparam logic EN_RST   = 1'b0;
   localparam logic RTC_RST  = 1'b0;
   localparam logic PEND_RST = 1'b0;

   // Byte-wise merge of a write into an existing 32-bit register value.
   function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                               input logic [31:0] new_val,
                                               input logic [3:0]  strb);
      logic [31:0] res;
      res = old_val;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) res[8*i +: 8] = new_val[8*i +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/iob_clint_rtc_gen_csr.sv
// CSR front end: address decode, write strobes and the registered one-cycle read response.
module iob_clint_rtc_gen_csr
   import iob_clint_rtc_gen_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic                clk,
   input  logic                arst_n,
   input  logic                cke,
   input  logic                avalid,
   input  logic [ADDR_W-1:0]   addr,
   input  logic [DATA_W/8-1:0] wstrb,
   input  logic [DATA_W-1:0]   ctrl_val,
   input  logic [DATA_W-1:0]   div_val,
   input  logic [DATA_W-1:0]   status_val,
   input  logic [DATA_W-1:0]   tick_lo_val,
   input  logic [DATA_W-1:0]   tick_hi_val,
   output logic                ctrl_we,
   output logic                div_we,
   output logic                tick_lo_re,
   output logic                rvalid,
   output logic [DATA_W-1:0]   rdata
);

   logic wr, rd;
   logic [DATA_W-1:0] rd_mux;

   assign wr = avalid & (|wstrb);
   assign rd = avalid & ~(|wstrb);

   assign ctrl_we    = wr & wstrb[0] & (addr == ADDR_W'(CTRL_ADDR));
   assign div_we     = wr & (addr == ADDR_W'(DIV_ADDR));
   assign tick_lo_re = rd & (addr == ADDR_W'(TICK_LO_ADDR));

   always_comb begin
      rd_mux = '0;
      case (addr)
         ADDR_W'(CTRL_ADDR):    rd_mux = ctrl_val;
         ADDR_W'(DIV_ADDR):     rd_mux = div_val;
         ADDR_W'(STATUS_ADDR):  rd_mux = status_val;
         ADDR_W'(TICK_LO_ADDR): rd_mux = tick_lo_val;
         ADDR_W'(TICK_HI_ADDR): rd_mux = tick_hi_val;
         default:               rd_mux = '0;
      endcase
   end

   // Read data is forced to zero whenever no response is being returned.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else if (cke) begin
         rvalid <= rd;
         rdata  <= rd ? rd_mux : '0;
      end
   end

endmodule

// File: rtl/iob_clint_rtc_gen.sv
// Programmable square-wave RTC for the CLINT rt_clk input.
// Optional 64-bit rising-edge tick counter enabled by defining IOB_CLINT_RTC_GEN_TICKCNT_EN.
module iob_clint_rtc_gen
   import iob_clint_rtc_gen_pkg::*;
#(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32,
   parameter int DIV_W  = 16
) (
   input  logic                clk_i,
   input  logic                arst_n_i,
   input  logic                cke_i,
   input  logic                iob_avalid,
   input  logic [ADDR_W-1:0]   iob_addr,
   input  logic [DATA_W-1:0]   iob_wdata,
   input  logic [DATA_W/8-1:0] iob_wstrb,
   output logic                iob_rvalid,
   output logic [DATA_W-1:0]   iob_rdata,
   output logic                iob_ready,
   output logic                rtc_o,
   output logic                rtc_tick_o
);

   logic en, pend_div, rtc, tick;
   logic ctrl_we, div_we, tick_lo_re, clr, wrap, load_div;
   logic [DIV_W-1:0] cnt, div_act, div_shadow, div_merged, div_src;
   logic [DATA_W-1:0] ctrl_val, div_val, status_val, tick_lo_val, tick_hi_val;

   assign iob_ready  = 1'b1;
   assign rtc_o      = rtc;
   assign rtc_tick_o = tick;

   assign div_merged = DIV_W'(merge_bytes(32'(div_shadow), iob_wdata, iob_wstrb));
   assign div_src    = div_we ? div_merged : div_shadow;
   assign clr        = ctrl_we & iob_wdata[CTRL_CLR_BIT];
   assign wrap       = (cnt >= div_act);
   // A pending divisor takes effect at a real wrap, or straight away while stopped.
   assign load_div   = (pend_div | div_we) & (~en | (wrap & ~clr));

   always_comb begin
      ctrl_val                  = '0;
      ctrl_val[CTRL_EN_BIT]     = en;
      status_val                = '0;
      status_val[STATUS_RUN_BIT]  = en;
      status_val[STATUS_PEND_BIT] = pend_div;
      div_val                   = DATA_W'(div_shadow);
   end

   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         en         <= EN_RST;
         pend_div   <= PEND_RST;
         rtc        <= RTC_RST;
         tick       <= 1'b0;
         cnt        <= '0;
         div_act    <= '0;
         div_shadow <= '0;
      end else if (cke_i) begin
         tick <= 1'b0;
         if (ctrl_we) en <= iob_wdata[CTRL_EN_BIT];
         if (div_we) div_shadow <= div_merged;
         if (clr) begin
            cnt <= '0;
            rtc <= 1'b0;
         end else if (en && wrap) begin
            cnt  <= '0;
            rtc  <= ~rtc;
            tick <= ~rtc;
         end else if (en) begin
            cnt <= cnt + DIV_W'(1);
         end
         if (load_div) begin
            div_act  <= div_src;
            pend_div <= 1'b0;
         end else if (div_we) begin
            pend_div <= 1'b1;
         end
      end
   end

`ifdef IOB_CLINT_RTC_GEN_TICKCNT_EN
   logic [63:0] tick_cnt;
   logic [31:0] tick_hi_snap;

   // HI is served from a snapshot taken on the LO read so the pair is coherent.
   always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
         tick_cnt     <= '0;
         tick_hi_snap <= '0;
      end else if (cke_i) begin
         if (clr) tick_cnt <= '0;
         else if (tick) tick_cnt <= tick_cnt + 64'd1;
         if (tick_lo_re) tick_hi_snap <= tick_cnt[63:32];
      end
   end

   assign tick_lo_val = DATA_W'(tick_cnt[31:0]);
   assign tick_hi_val = DATA_W'(tick_hi_snap);
`else
   logic unused_tick_lo_re;
   assign unused_tick_lo_re = tick_lo_re;
   assign tick_lo_val = '0;
   assign tick_hi_val = '0;
`endif

   iob_clint_rtc_gen_csr #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) csr (
      .clk        (clk_i),
      .arst_n     (arst_n_i),
      .cke        (cke_i),
      .avalid     (iob_avalid),
      .addr       (iob_addr),
      .wstrb      (iob_wstrb),
      .ctrl_val   (ctrl_val),
      .div_val    (div_val),
      .status_val (status_val),
      .tick_lo_val(tick_lo_val),
      .tick_hi_val(tick_hi_val),
      .ctrl_we    (ctrl_we),
      .div_we     (div_we),
      .tick_lo_re (tick_lo_re),
      .rvalid     (iob_rvalid),
      .rdata      (iob_rdata)
   );

endmodule
